// File: rtl/cache_mem_arbiter.sv
// Memory-side arbiter: serves icache fetches and dcache loads/stores against one single-port RAM.
// Optional round-robin arbitration is enabled by defining MEMARB_RR_EN; the default build uses fixed dcache priority.
module cache_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              iREN_i,
    input  logic [ADDR_W-1:0] iaddr_i,
    output logic              iwait_o,
    output logic [DATA_W-1:0] iload_o,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic [ADDR_W-1:0] daddr_i,
    input  logic [DATA_W-1:0] dstore_i,
    output logic              dwait_o,
    output logic [DATA_W-1:0] dload_o,
    output logic              ramREN_o,
    output logic              ramWEN_o,
    output logic [ADDR_W-1:0] ramaddr_o,
    output logic [DATA_W-1:0] ramstore_o,
    input  logic [DATA_W-1:0] ramload_i,
    input  logic [1:0]        ramstate_i
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dReq;
    logic               ramDone;
    logic               abort;

    assign dReq    = dREN_i | dWEN_i;
    assign ramDone = (ramstate_i == RAM_ACCESS);
    assign abort   = (ramstate_i == RAM_ERROR) || (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEMARB_RR_EN
    // lastGrant: 0 = icache, 1 = dcache; only completed transactions move it
    logic lastGrant_q, lastGrant_d;

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) lastGrant_q <= 1'b0;
        else       lastGrant_q <= lastGrant_d;
    end
`endif

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        iwait_o    = 1'b1;
        iload_o    = '0;
        dwait_o    = 1'b1;
        dload_o    = '0;
        ramREN_o   = 1'b0;
        ramWEN_o   = 1'b0;
        ramaddr_o  = '0;
        ramstore_o = '0;
`ifdef MEMARB_RR_EN
        lastGrant_d = lastGrant_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEMARB_RR_EN
                if (dReq && iREN_i) state_d = lastGrant_q ? IGNT : DGNT;
                else if (dReq)      state_d = DGNT;
                else if (iREN_i)    state_d = IGNT;
`else
                if (dReq)           state_d = DGNT;
                else if (iREN_i)    state_d = IGNT;
`endif
            end
            IGNT: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                if (!iREN_i) begin
                    state_d = IDLE;
                end else begin
                    ramREN_o  = 1'b1;
                    ramaddr_o = iaddr_i;
                    if (ramDone) begin
                        iwait_o = 1'b0;
                        iload_o = ramload_i;
                        state_d = IDLE;
`ifdef MEMARB_RR_EN
                        lastGrant_d = 1'b0;
`endif
                    end else if (abort) begin
                        state_d = IDLE;
                    end
                end
            end
            DGNT: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                if (!dReq) begin
                    state_d = IDLE;
                end else begin
                    ramWEN_o   = dWEN_i;
                    ramREN_o   = dREN_i & ~dWEN_i;
                    ramaddr_o  = daddr_i;
                    ramstore_o = dstore_i;
                    if (ramDone) begin
                        dwait_o = 1'b0;
                        dload_o = dWEN_i ? '0 : ramload_i;
                        state_d = IDLE;
`ifdef MEMARB_RR_EN
                        lastGrant_d = 1'b1;
`endif
                    end else if (abort) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a vector table for single transactions, then hand-written
// sequences for arbitration order, request drop, timeout, RAM error and asynchronous reset.
module tb_cache_mem_arbiter;

    logic        CLK_i = 1'b0;
    logic        RST_i;
    logic        iREN_i;
    logic [31:0] iaddr_i;
    logic        iwait_o;
    logic [31:0] iload_o;
    logic        dREN_i;
    logic        dWEN_i;
    logic [31:0] daddr_i;
    logic [31:0] dstore_i;
    logic        dwait_o;
    logic [31:0] dload_o;
    logic        ramREN_o;
    logic        ramWEN_o;
    logic [31:0] ramaddr_o;
    logic [31:0] ramstore_o;
    logic [31:0] ramload_i;
    logic [1:0]  ramstate_i;

    int compared   = 0;
    int mismatched = 0;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
        .CLK_i(CLK_i), .RST_i(RST_i),
        .iREN_i(iREN_i), .iaddr_i(iaddr_i), .iwait_o(iwait_o), .iload_o(iload_o),
        .dREN_i(dREN_i), .dWEN_i(dWEN_i), .daddr_i(daddr_i), .dstore_i(dstore_i),
        .dwait_o(dwait_o), .dload_o(dload_o),
        .ramREN_o(ramREN_o), .ramWEN_o(ramWEN_o), .ramaddr_o(ramaddr_o),
        .ramstore_o(ramstore_o), .ramload_i(ramload_i), .ramstate_i(ramstate_i)
    );

    always #5 CLK_i = ~CLK_i;

    typedef struct {
        string       name;
        logic        iREN;
        logic [31:0] iaddr;
        logic        dREN;
        logic        dWEN;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  ramstate;
        logic        eIwait;
        logic [31:0] eIload;
        logic        eDwait;
        logic [31:0] eDload;
        logic        eRamREN;
        logic        eRamWEN;
        logic [31:0] eRamaddr;
        logic [31:0] eRamstore;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iR, input logic [31:0] ia, input logic dR, input logic dW,
                         input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                         input logic [1:0] rs);
        iREN_i = iR; iaddr_i = ia; dREN_i = dR; dWEN_i = dW;
        daddr_i = da; dstore_i = ds; ramload_i = rl; ramstate_i = rs;
        #1;
    endtask

    task automatic checkAll(input string tag, input logic eIw, input logic [31:0] eIl,
                            input logic eDw, input logic [31:0] eDl, input logic eR,
                            input logic eW, input logic [31:0] eA, input logic [31:0] eS);
        chk({tag, ".iwait"},    {31'd0, iwait_o},  {31'd0, eIw});
        chk({tag, ".iload"},    iload_o,           eIl);
        chk({tag, ".dwait"},    {31'd0, dwait_o},  {31'd0, eDw});
        chk({tag, ".dload"},    dload_o,           eDl);
        chk({tag, ".ramREN"},   {31'd0, ramREN_o}, {31'd0, eR});
        chk({tag, ".ramWEN"},   {31'd0, ramWEN_o}, {31'd0, eW});
        chk({tag, ".ramaddr"},  ramaddr_o,         eA);
        chk({tag, ".ramstore"}, ramstore_o,        eS);
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.iREN, v.iaddr, v.dREN, v.dWEN, v.daddr, v.dstore, v.ramload, v.ramstate);
    endtask

    task automatic checkOutput(input vec_t v);
        checkAll(v.name, v.eIwait, v.eIload, v.eDwait, v.eDload, v.eRamREN, v.eRamWEN,
                 v.eRamaddr, v.eRamstore);
    endtask

    task automatic idleCycle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
        checkAll(tag, 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
    endtask

    initial begin
        // Each row is one clock cycle; inputs change at negedge, outputs checked 1 time unit later
        vecs[0]  = '{"idle_access",   0, 32'h40, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF, 2'd2, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,  32'h0};
        vecs[1]  = '{"i_req",         1, 32'h40, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF, 2'd0, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,  32'h0};
        vecs[2]  = '{"i_gnt",         1, 32'h40, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF, 2'd0, 1, 32'h0,        1, 32'h0,        1, 0, 32'h40, 32'h0};
        vecs[3]  = '{"i_access",      1, 32'h40, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF, 2'd2, 0, 32'hDEADBEEF, 1, 32'h0,        1, 0, 32'h40, 32'h0};
        vecs[4]  = '{"i_release",     0, 32'h0,  0, 0, 32'h0,  32'h0,    32'hDEADBEEF, 2'd0, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,  32'h0};
        vecs[5]  = '{"d_wr_req",      0, 32'h0,  0, 1, 32'h80, 32'h1234, 32'h0,        2'd0, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,  32'h0};
        vecs[6]  = '{"d_wr_busy1",    0, 32'h0,  0, 1, 32'h80, 32'h1234, 32'h0,        2'd1, 1, 32'h0,        1, 32'h0,        0, 1, 32'h80, 32'h1234};
        vecs[7]  = '{"d_wr_busy2",    0, 32'h0,  0, 1, 32'h80, 32'h1234, 32'h0,        2'd1, 1, 32'h0,        1, 32'h0,        0, 1, 32'h80, 32'h1234};
        vecs[8]  = '{"d_wr_busy3",    0, 32'h0,  0, 1, 32'h80, 32'h1234, 32'h0,        2'd1, 1, 32'h0,        1, 32'h0,        0, 1, 32'h80, 32'h1234};
        vecs[9]  = '{"d_wr_access",   0, 32'h0,  0, 1, 32'h80, 32'h1234, 32'h5555,     2'd2, 1, 32'h0,        0, 32'h0,        0, 1, 32'h80, 32'h1234};
        vecs[10] = '{"d_release",     0, 32'h0,  0, 0, 32'h0,  32'h0,    32'h0,        2'd0, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,  32'h0};
        vecs[11] = '{"d_rd_req",      0, 32'h0,  1, 0, 32'hC4, 32'h0,    32'hCAFEF00D, 2'd0, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,  32'h0};
        vecs[12] = '{"d_rd_access",   0, 32'h0,  1, 0, 32'hC4, 32'h0,    32'hCAFEF00D, 2'd2, 1, 32'h0,        0, 32'hCAFEF00D, 1, 0, 32'hC4, 32'h0};
        vecs[13] = '{"d_both_req",    0, 32'h0,  1, 1, 32'h10, 32'hAB,   32'h99,       2'd0, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,  32'h0};
        vecs[14] = '{"d_both_access", 0, 32'h0,  1, 1, 32'h10, 32'hAB,   32'h99,       2'd2, 1, 32'h0,        0, 32'h0,        0, 1, 32'h10, 32'hAB};
        vecs[15] = '{"final_idle",    0, 32'h0,  0, 0, 32'h0,  32'h0,    32'h1,        2'd2, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,  32'h0};

        RST_i = 1'b1;
        drive(1, 32'h40, 1, 1, 32'h80, 32'h55, 32'hDEADBEEF, 2'd2);
        @(negedge CLK_i);
        @(negedge CLK_i);
        checkAll("reset", 1, 0, 1, 0, 0, 0, 0, 0);
        RST_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
            @(negedge CLK_i);
        end

        // Both caches request continuously against a 0-wait RAM; reset first so the arbiter starts fresh
        RST_i = 1'b1;
        #2;
        RST_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] rl;
            logic        expD;
            rl = 32'h1000 + 32'(k);
            drive(1, 32'h100, 1, 0, 32'h200, 0, rl, 2'd2);
`ifdef MEMARB_RR_EN
            expD = ((k / 2) % 2) == 0;
`else
            expD = 1'b1;
`endif
            if (k % 2 == 0)
                checkAll($sformatf("arb_idle%0d", k / 2), 1, 0, 1, 0, 0, 0, 0, 0);
            else if (expD)
                checkAll($sformatf("arb_txn%0d", k / 2), 1, 0, 0, rl, 1, 0, 32'h200, 0);
            else
                checkAll($sformatf("arb_txn%0d", k / 2), 0, rl, 1, 0, 1, 0, 32'h100, 0);
            @(negedge CLK_i);
        end
        idleCycle("arb_done");

        // icache drops its request in the second BUSY cycle of its grant
        drive(1, 32'h44, 0, 0, 0, 0, 0, 2'd1);
        checkAll("drop_req", 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
        drive(1, 32'h44, 0, 0, 0, 0, 0, 2'd1);
        checkAll("drop_busy1", 1, 0, 1, 0, 1, 0, 32'h44, 0);
        @(negedge CLK_i);
        drive(0, 32'h44, 0, 0, 0, 0, 32'h4444, 2'd1);
        checkAll("drop_busy2", 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
        drive(1, 32'h44, 0, 0, 0, 0, 32'h4444, 2'd2);
        checkAll("drop_idle", 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
        drive(1, 32'h44, 0, 0, 0, 0, 32'h4444, 2'd2);
        checkAll("drop_regrant", 0, 32'h4444, 1, 0, 1, 0, 32'h44, 0);
        @(negedge CLK_i);
        idleCycle("drop_done");

        // RAM stuck BUSY: 64 granted cycles, one IDLE cycle, then a fresh grant
        for (int c = 0; c < 70; c++) begin
            logic g;
            g = (c >= 1 && c <= 64) || (c >= 66);
            drive(0, 0, 1, 0, 32'h20, 0, 32'h7777, 2'd1);
            checkAll($sformatf("tmo_c%0d", c), 1, 0, 1, 0, g, 0, g ? 32'h20 : 32'h0, 0);
            @(negedge CLK_i);
        end
        idleCycle("tmo_drop");
        idleCycle("tmo_done");

        // RAM error during an icache grant
        drive(1, 32'h48, 0, 0, 0, 0, 0, 2'd0);
        checkAll("err_req", 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
        drive(1, 32'h48, 0, 0, 0, 0, 32'h4848, 2'd3);
        checkAll("err_gnt", 1, 0, 1, 0, 1, 0, 32'h48, 0);
        @(negedge CLK_i);
        drive(1, 32'h48, 0, 0, 0, 0, 32'h4848, 2'd2);
        checkAll("err_idle", 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
        drive(1, 32'h48, 0, 0, 0, 0, 32'h4848, 2'd2);
        checkAll("err_regrant", 0, 32'h4848, 1, 0, 1, 0, 32'h48, 0);
        @(negedge CLK_i);
        idleCycle("err_done");

        // Asynchronous reset while a dcache write is on the RAM
        drive(0, 0, 0, 1, 32'h80, 32'h77, 0, 2'd1);
        checkAll("rst_req", 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
        drive(0, 0, 0, 1, 32'h80, 32'h77, 0, 2'd1);
        checkAll("rst_gnt", 1, 0, 1, 0, 0, 1, 32'h80, 32'h77);
        RST_i = 1'b1;
        #1;
        checkAll("rst_async", 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
        RST_i = 1'b0;
        drive(0, 0, 0, 1, 32'h80, 32'h77, 0, 2'd2);
        checkAll("rst_idle", 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK_i);
        drive(0, 0, 0, 1, 32'h80, 32'h77, 0, 2'd2);
        checkAll("rst_regrant", 1, 0, 0, 0, 0, 1, 32'h80, 32'h77);
        @(negedge CLK_i);
        idleCycle("rst_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
